// File: rtl/channel_scan_mux_pkg.sv
// Shared definitions for channel_scan_mux: FSM state encoding and select-width helper.
package channel_scan_mux_pkg;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } scan_state_e;

    // A one-channel mux still needs a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/channel_scan_mux_rr_next_enabled.sv
// Combinational cyclic priority search: the first set mask bit after (or at) cur_idx, wrapping to 0.
module rr_next_enabled #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur_idx,
    input  logic              incl_cur,
    output logic [SEL_W-1:0]  next_idx,
    output logic              found,
    output logic              wrapped
);

    logic             found_hi;
    logic [SEL_W-1:0] idx_hi;
    logic [SEL_W-1:0] idx_lo;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        found    = 1'b0;
        found_hi = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        // Descending scan: the last hit written is the lowest index in each half.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found  = 1'b1;
                idx_lo = SEL_W'(i);
                if (i > int'(cur_idx) || (incl_cur && i == int'(cur_idx))) begin
                    found_hi = 1'b1;
                    idx_hi   = SEL_W'(i);
                end
            end
        end
        next_idx = found_hi ? idx_hi : idx_lo;
        wrapped  = found && !found_hi;
    end

endmodule

// File: rtl/channel_scan_mux.sv
// N:1 channel mux with registered output: manual select or auto-scan over mask-enabled channels with a dwell count.
module channel_scan_mux
    import channel_scan_mux_pkg::*;
#(
    parameter int  NUM_CH  = 8,
    parameter int  DATA_W  = 1,
    parameter int  DWELL_W = 16,
    localparam int SEL_W   = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] I,
    input  logic [SEL_W-1:0]         S,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [DWELL_W-1:0]       dwell,
    output logic [DATA_W-1:0]        Y,
    output logic                     Y_valid,
    output logic [SEL_W-1:0]         cur_sel,
    output logic                     wrap
);

    scan_state_e        state;
    scan_state_e        next_state;
    logic               from_manual;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_d;
    logic [DWELL_W-1:0] dwell_last;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   next_idx;
    logic               found;
    logic               wrapped;
    logic               scan_edge;
    logic               scan_entry;
    logic               cur_en;
    logic               expired;
    logic               wrap_d;
    logic               sel_ok;
    logic               sel_en;
    logic               valid_d;
    logic [DATA_W-1:0]  y_d;

    // Entry and advance never happen on the same edge, so one searcher serves both.
    rr_next_enabled #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_next (
        .mask     (ch_mask),
        .cur_idx  (cur_sel),
        .incl_cur (scan_entry),
        .next_idx (next_idx),
        .found    (found),
        .wrapped  (wrapped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= ST_MANUAL;
        else        state <= next_state;
    end

    always_comb begin
        next_state = ST_MANUAL;
        unique case (state)
            ST_MANUAL: next_state = mode ? ST_SCAN : ST_MANUAL;
            ST_SCAN:   next_state = mode ? ST_SCAN : ST_MANUAL;
            default:   next_state = ST_MANUAL;
        endcase
    end

    // A scan edge needs both the registered state and live mode; a falling mode returns to S on that same edge.
    assign scan_edge  = (state == ST_SCAN) && mode;
    assign scan_entry = scan_edge && from_manual;
    assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign expired    = (cnt >= dwell_last);

    always_comb begin
        cur_en = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            if (cur_sel == SEL_W'(k)) cur_en = ch_mask[k];
    end

    always_comb begin
        sel    = S;
        cnt_d  = '0;
        wrap_d = 1'b0;
        if (scan_edge) begin
            sel = cur_sel;
            if (found) begin
                if (scan_entry) begin
                    sel = next_idx;
                end else if (!cur_en || expired) begin
                    sel    = next_idx;
                    wrap_d = wrapped;
                end else begin
                    cnt_d = cnt + DWELL_W'(1);
                end
            end
        end
    end

    always_comb begin
        y_d    = '0;
        sel_ok = 1'b0;
        sel_en = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_ok = 1'b1;
                sel_en = ch_mask[k];
                y_d    = I[k*DATA_W +: DATA_W];
            end
        end
        valid_d = sel_ok && (!scan_edge || sel_en);
        if (!valid_d) y_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y           <= '0;
            Y_valid     <= 1'b0;
            cur_sel     <= '0;
            wrap        <= 1'b0;
            cnt         <= '0;
            from_manual <= 1'b0;
        end else begin
            Y           <= y_d;
            Y_valid     <= valid_d;
            cur_sel     <= sel;
            wrap        <= wrap_d;
            cnt         <= cnt_d;
            from_manual <= (state == ST_MANUAL);
        end
    end

endmodule

// File: tb/tb_channel_scan_mux.sv
// Self-checking bench: an 8-channel and a 6-channel instance share stimulus and are compared to a list-based model.
module tb_channel_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ibus;
    logic [2:0]  S;
    logic        mode;
    logic [7:0]  mask;
    logic [15:0] dwell;

    logic [3:0]  y8, y6;
    logic        v8, v6;
    logic [2:0]  cur8, cur6;
    logic        wrap8, wrap6;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: edges seen in a row with mode=1, current index and dwell count.
    int         run_len [2];
    int         m_cur   [2];
    int         m_cnt   [2];
    logic [3:0] e_y     [2];
    logic       e_v     [2];
    logic [2:0] e_cur   [2];
    logic       e_wrap  [2];

    int exp_seq  [15] = '{1, 1, 1, 2, 2, 2, 5, 5, 5, 7, 7, 7, 1, 1, 1};

    always #5 clk = ~clk;

    channel_scan_mux #(.NUM_CH(8), .DATA_W(4), .DWELL_W(16)) dut8 (
        .clk (clk), .rst_n (rst_n), .I (ibus), .S (S), .mode (mode),
        .ch_mask (mask), .dwell (dwell),
        .Y (y8), .Y_valid (v8), .cur_sel (cur8), .wrap (wrap8)
    );

    channel_scan_mux #(.NUM_CH(6), .DATA_W(4), .DWELL_W(16)) dut6 (
        .clk (clk), .rst_n (rst_n), .I (ibus[23:0]), .S (S), .mode (mode),
        .ch_mask (mask[5:0]), .dwell (dwell),
        .Y (y6), .Y_valid (v6), .cur_sel (cur6), .wrap (wrap6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            run_len[d] = 0; m_cur[d] = 0; m_cnt[d] = 0;
            e_y[d] = '0; e_v[d] = 1'b0; e_cur[d] = '0; e_wrap[d] = 1'b0;
        end
    endfunction

    // First enabled index past 'from' (or at it when incl), else the lowest enabled one.
    function automatic int pick_next(input int en[$], input int from, input bit incl);
        foreach (en[j])
            if (en[j] > from || (incl && en[j] == from)) return en[j];
        return en[0];
    endfunction

    function automatic void model_step(input int d);
        int nc;
        int en[$];
        int sel, cnt_n, lim;
        bit scan_edge, entry, wr, valid;
        nc        = (d == 0) ? 8 : 6;
        for (int k = 0; k < nc; k++) if (mask[k]) en.push_back(k);
        scan_edge = mode && (run_len[d] >= 1);
        entry     = scan_edge && (run_len[d] == 1);
        lim       = (dwell == 0) ? 0 : int'(dwell) - 1;
        sel = int'(S); cnt_n = 0; wr = 1'b0;
        if (scan_edge) begin
            sel = m_cur[d];
            if (en.size() == 0) begin
                sel = m_cur[d];
            end else if (entry) begin
                sel = pick_next(en, m_cur[d], 1'b1);
            end else if (!(m_cur[d] < nc && mask[m_cur[d]]) || m_cnt[d] >= lim) begin
                sel = pick_next(en, m_cur[d], 1'b0);
                wr  = (sel <= m_cur[d]);
            end else begin
                cnt_n = m_cnt[d] + 1;
            end
        end
        valid     = (sel < nc) && (!scan_edge || mask[sel]);
        e_y[d]    = valid ? ibus[sel*4 +: 4] : 4'h0;
        e_v[d]    = valid;
        e_cur[d]  = 3'(sel);
        e_wrap[d] = wr;
        m_cur[d]  = sel;
        m_cnt[d]  = cnt_n;
        run_len[d] = mode ? ((run_len[d] < 2) ? run_len[d] + 1 : 2) : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("y8",    32'(y8),    32'(e_y[0]));
            check("v8",    32'(v8),    32'(e_v[0]));
            check("cur8",  32'(cur8),  32'(e_cur[0]));
            check("wrap8", 32'(wrap8), 32'(e_wrap[0]));
            check("y6",    32'(y6),    32'(e_y[1]));
            check("v6",    32'(v6),    32'(e_v[1]));
            check("cur6",  32'(cur6),  32'(e_cur[1]));
            check("wrap6", 32'(wrap6), 32'(e_wrap[1]));
        end
    end

    initial begin
        int prev, budget, nwrap;
        rst_n = 1'b0; mode = 1'b0; S = '0; mask = '0; dwell = '0; ibus = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_y",    32'(y8),    32'h0);
        check("rst_v",    32'(v8),    32'h0);
        check("rst_cur",  32'(cur8),  32'h0);
        check("rst_wrap", 32'(wrap8), 32'h0);
        rst_n = 1'b1;

        // Manual sweep; the 6-channel instance sees 6 and 7 as out of range.
        ibus = 32'h7654_3210;
        for (int k = 0; k < 8; k++) begin
            S = 3'(k);
            step();
            check("sweep_y",   32'(y8),   32'(k));
            check("sweep_v",   32'(v8),   32'h1);
            check("sweep_cur", 32'(cur8), 32'(k));
            check("oor_y6",    32'(y6),   (k < 6) ? 32'(k) : 32'h0);
            check("oor_v6",    32'(v6),   (k < 6) ? 32'h1 : 32'h0);
        end
        S = 3'd5;
        step();
        check("back_y6", 32'(y6), 32'h5);
        check("back_v6", 32'(v6), 32'h1);

        // Scan over channels 1,2,5,7 holding each for 3 cycles.
        mode = 1'b1; S = 3'd0; mask = 8'b1010_0110; dwell = 16'd3;
        step();
        for (int t = 0; t < 15; t++) begin
            step();
            check("scan_seq",  32'(cur8),  32'(exp_seq[t]));
            check("scan_wrap", 32'(wrap8), (t == 12) ? 32'h1 : 32'h0);
        end

        // Single enabled channel re-selects itself and wraps on every expiry.
        mask = 8'b0000_1000; dwell = 16'd2;
        for (int t = 0; t < 4; t++) step();
        nwrap = 0;
        for (int t = 0; t < 8; t++) begin
            step();
            check("single_cur", 32'(cur8), 32'h3);
            nwrap += int'(wrap8);
        end
        check("single_wraps", 32'(nwrap), 32'h4);

        // Dwell 0 behaves like 1: a new channel every cycle.
        mask = 8'b1010_0110; dwell = 16'd0;
        for (int t = 0; t < 4; t++) begin
            prev = int'(cur8);
            step();
            check("dwell0_moves", 32'(int'(cur8) != prev), 32'h1);
        end

        // Empty mask freezes the index and invalidates the output.
        prev = int'(cur8);
        mask = 8'h00;
        for (int t = 0; t < 3; t++) begin
            step();
            check("empty_y",   32'(y8),   32'h0);
            check("empty_v",   32'(v8),   32'h0);
            check("empty_cur", 32'(cur8), 32'(prev));
        end

        // Mid-dwell: drop the current channel at count 4, then cut dwell at count 5.
        mask = 8'b1010_0110; dwell = 16'd10;
        budget = 40;
        while (m_cnt[0] != 4 && budget > 0) begin step(); budget--; end
        check("wait_cnt4", 32'(budget > 0), 32'h1);
        prev = int'(cur8);
        mask[prev] = 1'b0;
        step();
        check("drop_adv", 32'(int'(cur8) != prev), 32'h1);
        budget = 40;
        while (m_cnt[0] != 5 && budget > 0) begin step(); budget--; end
        check("wait_cnt5", 32'(budget > 0), 32'h1);
        prev = int'(cur8);
        dwell = 16'd2;
        step();
        check("dwell_cut", 32'(int'(cur8) != prev), 32'h1);

        // Asynchronous reset between edges, then one manual cycle before scan resumes.
        mask = 8'b1010_0110; dwell = 16'd3;
        for (int t = 0; t < 5; t++) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_y",    32'(y8),    32'h0);
        check("arst_v",    32'(v8),    32'h0);
        check("arst_cur",  32'(cur8),  32'h0);
        check("arst_wrap", 32'(wrap8), 32'h0);
        @(negedge clk);
        ibus = 32'h7654_3210; S = 3'd4; mode = 1'b1; rst_n = 1'b1;
        step();
        check("post_rst_cur", 32'(cur8), 32'h4);
        check("post_rst_y",   32'(y8),   32'h4);
        step();
        check("post_rst_entry", 32'(cur8), 32'h5);

        // Randomized traffic.
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            S    = 3'($urandom_range(0, 7));
            ibus = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mask = 8'h00;
                    1:       mask = 8'(1 << $urandom_range(0, 7));
                    default: mask = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 15) == 0) dwell = 16'($urandom_range(0, 5));
            step();
        end

        #2 chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
